// File: rtl/mrp_rx_arb_pkg.sv
// Shared types and helpers for the MRP receive-engine arbiter.
//   arb_state_e : arbiter FSM state encoding
//   src_w()     : width of a source index, never narrower than one bit
package mrp_rx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mrp_rr_pick.sv
// Combinational rotate-priority picker: finds the first set request bit
// starting at index prio and wrapping around.
//   req      : request vector, one bit per source
//   prio     : index searched first
//   pick_val : at least one request is set
//   pick_idx : index of the winning request (0 when pick_val is 0)
module mrp_rr_pick
  import mrp_rx_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   prio,
  output logic               pick_val,
  output logic [SRC_W-1:0]   pick_idx
);

  // prio < NUM_SRC and off < NUM_SRC, so a single subtraction wraps the sum.
  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SRC_W'(s);
  endfunction

  // Scan from prio upward; the first hit wins.
  always_comb begin
    pick_val = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!pick_val && req[wrap_idx(prio, i)]) begin
        pick_val = 1'b1;
        pick_idx = wrap_idx(prio, i);
      end
    end
  end

endmodule

// File: rtl/mrp_rx_engine_arb.sv
// Shares one MRP engine receive port among NUM_SRC receive-input controllers.
// A source is locked in for a whole message (one header plus data flits up to
// and including the last one); priority rotates round-robin between messages.
//   clk, rst_n                 : clock, async active-low reset
//   src_hdr_val/src_hdr        : per-source header stream in
//   src_hdr_rdy                : per-source header accept
//   src_data_val/src_data/last : per-source data stream in
//   src_data_rdy               : per-source data accept
//   eng_hdr_*                  : header stream to the engine
//   eng_data_*                 : data stream to the engine
//   grant_val/grant_src        : message in flight and its owning source
module mrp_rx_engine_arb
  import mrp_rx_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  parameter  int unsigned HDR_W   = 128,
  parameter  int unsigned DATA_W  = 512,
  localparam int unsigned SRC_W   = src_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_hdr_val,
  input  logic [NUM_SRC*HDR_W-1:0]  src_hdr,
  output logic [NUM_SRC-1:0]        src_hdr_rdy,
  input  logic [NUM_SRC-1:0]        src_data_val,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_data_last,
  output logic [NUM_SRC-1:0]        src_data_rdy,
  output logic                      eng_hdr_val,
  output logic [HDR_W-1:0]          eng_hdr,
  input  logic                      eng_hdr_rdy,
  output logic                      eng_data_val,
  output logic [DATA_W-1:0]         eng_data,
  output logic                      eng_data_last,
  input  logic                      eng_data_rdy,
  output logic                      grant_val,
  output logic [SRC_W-1:0]          grant_src
);

  arb_state_e         r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_grant_src, w_grant_src_nxt;
  logic [SRC_W-1:0]   r_prio, w_prio_nxt;
  logic               r_hdr_done, w_hdr_done_nxt;
  logic               r_data_done, w_data_done_nxt;

  logic               w_pick_val;
  logic [SRC_W-1:0]   w_pick_idx;
  logic               w_busy;
  logic [NUM_SRC-1:0] w_sel;
  logic               w_g_hdr_val, w_g_data_val, w_g_last;
  logic               w_hdr_hs, w_last_hs, w_hdr_fin, w_data_fin;
  logic [SRC_W-1:0]   w_prio_after;

  // Arbitration only looks at header valids; orphan data never requests.
  mrp_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req      (src_hdr_val),
    .prio     (r_prio),
    .pick_val (w_pick_val),
    .pick_idx (w_pick_idx)
  );

  assign w_busy = (r_state == BUSY);

  // Select the granted source's streams.
  always_comb begin
    w_sel        = '0;
    w_g_hdr_val  = 1'b0;
    w_g_data_val = 1'b0;
    w_g_last     = 1'b0;
    eng_hdr      = '0;
    eng_data     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SRC_W'(i) == r_grant_src) begin
        w_sel[i]     = 1'b1;
        w_g_hdr_val  = src_hdr_val[i];
        w_g_data_val = src_data_val[i];
        w_g_last     = src_data_last[i];
        eng_hdr      = src_hdr[i*HDR_W +: HDR_W];
        eng_data     = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready depends only on engine ready and local state, never on source valid.
  assign eng_hdr_val   = w_busy & w_g_hdr_val & ~r_hdr_done;
  assign eng_data_val  = w_busy & w_g_data_val & ~r_data_done;
  assign eng_data_last = w_busy & w_g_last;
  assign src_hdr_rdy   = w_sel & {NUM_SRC{w_busy & eng_hdr_rdy & ~r_hdr_done}};
  assign src_data_rdy  = w_sel & {NUM_SRC{w_busy & eng_data_rdy & ~r_data_done}};

  assign grant_val = w_busy;
  assign grant_src = r_grant_src;

  assign w_hdr_hs   = eng_hdr_val & eng_hdr_rdy;
  assign w_last_hs  = eng_data_val & eng_data_rdy & eng_data_last;
  assign w_hdr_fin  = r_hdr_done | w_hdr_hs;
  assign w_data_fin = r_data_done | w_last_hs;

  // Next priority after the current owner, wrapping at NUM_SRC.
  assign w_prio_after = (32'(r_grant_src) >= NUM_SRC - 1) ? '0
                                                          : r_grant_src + SRC_W'(1);

  // Next-state logic; completion counts this cycle's handshakes.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_src_nxt = r_grant_src;
    w_prio_nxt      = r_prio;
    w_hdr_done_nxt  = r_hdr_done;
    w_data_done_nxt = r_data_done;
    unique case (r_state)
      IDLE: begin
        if (w_pick_val) begin
          w_state_nxt     = BUSY;
          w_grant_src_nxt = w_pick_idx;
          w_hdr_done_nxt  = 1'b0;
          w_data_done_nxt = 1'b0;
        end
      end
      BUSY: begin
        w_hdr_done_nxt  = w_hdr_fin;
        w_data_done_nxt = w_data_fin;
        if (w_hdr_fin && w_data_fin) begin
          w_state_nxt     = IDLE;
          w_prio_nxt      = w_prio_after;
          w_hdr_done_nxt  = 1'b0;
          w_data_done_nxt = 1'b0;
        end
      end
      default: w_state_nxt = arb_state_e'(1'bx);
    endcase
  end

  // State and per-message registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_src <= '0;
      r_prio      <= '0;
      r_hdr_done  <= 1'b0;
      r_data_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_src <= w_grant_src_nxt;
      r_prio      <= w_prio_nxt;
      r_hdr_done  <= w_hdr_done_nxt;
      r_data_done <= w_data_done_nxt;
    end
  end

endmodule

// File: tb/tb_mrp_rx_engine_arb.sv
// Directed bench for mrp_rx_engine_arb (NUM_SRC=4, HDR_W=128, DATA_W=512).
module tb_mrp_rx_engine_arb;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned HDR_W   = 128;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned SRC_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_SRC-1:0]        src_hdr_val;
  logic [NUM_SRC*HDR_W-1:0]  src_hdr;
  logic [NUM_SRC-1:0]        src_hdr_rdy;
  logic [NUM_SRC-1:0]        src_data_val;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_data_last;
  logic [NUM_SRC-1:0]        src_data_rdy;
  logic                      eng_hdr_val;
  logic [HDR_W-1:0]          eng_hdr;
  logic                      eng_hdr_rdy;
  logic                      eng_data_val;
  logic [DATA_W-1:0]         eng_data;
  logic                      eng_data_last;
  logic                      eng_data_rdy;
  logic                      grant_val;
  logic [SRC_W-1:0]          grant_src;

  int n_cmp = 0;
  int n_err = 0;

  mrp_rx_engine_arb #(.NUM_SRC(NUM_SRC), .HDR_W(HDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_hdr_val   (src_hdr_val),
    .src_hdr       (src_hdr),
    .src_hdr_rdy   (src_hdr_rdy),
    .src_data_val  (src_data_val),
    .src_data      (src_data),
    .src_data_last (src_data_last),
    .src_data_rdy  (src_data_rdy),
    .eng_hdr_val   (eng_hdr_val),
    .eng_hdr       (eng_hdr),
    .eng_hdr_rdy   (eng_hdr_rdy),
    .eng_data_val  (eng_data_val),
    .eng_data      (eng_data),
    .eng_data_last (eng_data_last),
    .eng_data_rdy  (eng_data_rdy),
    .grant_val     (grant_val),
    .grant_src     (grant_src)
  );

  always #5 clk = ~clk;

  function automatic logic [HDR_W-1:0] hdr_of(input int s);
    return {64'h0, 32'hBEEF_0000, 16'(s), 16'hC0DE};
  endfunction

  function automatic logic [DATA_W-1:0] dat_of(input int s, input int n);
    return {448'h0, 32'hDA7A_0000, 16'(s), 16'(n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_src();
    src_hdr_val   = '0;
    src_hdr       = '0;
    src_data_val  = '0;
    src_data      = '0;
    src_data_last = '0;
  endtask

  task automatic drive_src(input int s, input logic hv, input logic dv,
                           input int n, input logic last);
    src_hdr_val[s]                  = hv;
    src_hdr[s*HDR_W +: HDR_W]       = hdr_of(s);
    src_data_val[s]                 = dv;
    src_data[s*DATA_W +: DATA_W]    = dat_of(s, n);
    src_data_last[s]                = last;
  endtask

  task automatic test_reset();
    clr_src();
    eng_hdr_rdy  = 1'b1;
    eng_data_rdy = 1'b1;
    rst_n        = 1'b0;
    #12;
    n_cmp++;
    if ({grant_val, grant_src, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val} !== 12'h0) begin
      n_err++; $display("FAIL reset_outputs: got %0h expected 0",
        {grant_val, grant_src, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val});
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({grant_val, grant_src, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val} !== 12'h0) begin
      n_err++; $display("FAIL post_release_outputs: got %0h expected 0",
        {grant_val, grant_src, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val});
    end
  endtask

  task automatic test_single();
    tick(); drive_src(2, 1'b1, 1'b1, 0, 1'b0); #1;
    n_cmp++;
    if (grant_val !== 1'b0) begin n_err++; $display("FAIL single_idle_grant: got %0h expected 0", grant_val); end
    tick(); #1;
    n_cmp++;
    if ({grant_val, grant_src} !== 3'b1_10) begin
      n_err++; $display("FAIL single_grant: got %0h expected 6", {grant_val, grant_src});
    end
    n_cmp++;
    if ({eng_hdr_val, eng_hdr} !== {1'b1, hdr_of(2)}) begin
      n_err++; $display("FAIL single_hdr: got %0h expected %0h", {eng_hdr_val, eng_hdr}, {1'b1, hdr_of(2)});
    end
    n_cmp++;
    if ({eng_data_val, eng_data} !== {1'b1, dat_of(2, 0)}) begin
      n_err++; $display("FAIL single_flit0: got %0h expected %0h", {eng_data_val, eng_data}, {1'b1, dat_of(2, 0)});
    end
    n_cmp++;
    if ({src_hdr_rdy, src_data_rdy} !== 8'b0100_0100) begin
      n_err++; $display("FAIL single_rdy: got %0h expected 44", {src_hdr_rdy, src_data_rdy});
    end
    tick(); drive_src(2, 1'b0, 1'b1, 1, 1'b0); #1;
    n_cmp++;
    if ({eng_hdr_val, eng_data_last, eng_data} !== {2'b00, dat_of(2, 1)}) begin
      n_err++; $display("FAIL single_flit1: got %0h expected %0h",
        {eng_hdr_val, eng_data_last, eng_data}, {2'b00, dat_of(2, 1)});
    end
    tick(); drive_src(2, 1'b0, 1'b1, 2, 1'b1); #1;
    n_cmp++;
    if ({grant_val, eng_data_last, eng_data} !== {2'b11, dat_of(2, 2)}) begin
      n_err++; $display("FAIL single_flit2_last: got %0h expected %0h",
        {grant_val, eng_data_last, eng_data}, {2'b11, dat_of(2, 2)});
    end
    // Everyone requests in the IDLE gap: the rotated priority must favour 3.
    tick();
    for (int s = 0; s < 4; s++) drive_src(s, 1'b1, 1'b1, 0, 1'b1);
    #1;
    n_cmp++;
    if (grant_val !== 1'b0) begin n_err++; $display("FAIL single_back_to_idle: got %0h expected 0", grant_val); end
    tick(); #1;
    n_cmp++;
    if ({grant_val, grant_src} !== 3'b1_11) begin
      n_err++; $display("FAIL single_prio_is_3: got %0h expected 7", {grant_val, grant_src});
    end
    tick(); clr_src(); #1;
    n_cmp++;
    if (grant_val !== 1'b0) begin n_err++; $display("FAIL single_src3_done: got %0h expected 0", grant_val); end
  endtask

  task automatic test_round_robin();
    tick();
    for (int s = 0; s < 4; s++) drive_src(s, 1'b1, 1'b1, 0, 1'b1);
    #1;
    n_cmp++;
    if (grant_val !== 1'b0) begin n_err++; $display("FAIL rr_start_idle: got %0h expected 0", grant_val); end
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      n_cmp++;
      if ({grant_val, grant_src} !== {1'b1, 2'(k % 4)}) begin
        n_err++; $display("FAIL rr_grant_%0d: got %0h expected %0h", k, {grant_val, grant_src}, {1'b1, 2'(k % 4)});
      end
      n_cmp++;
      if (eng_data !== dat_of(k % 4, 0)) begin
        n_err++; $display("FAIL rr_data_%0d: got %0h expected %0h", k, eng_data, dat_of(k % 4, 0));
      end
      tick();
      if (k == 4) clr_src();
      #1;
      n_cmp++;
      if (grant_val !== 1'b0) begin n_err++; $display("FAIL rr_gap_%0d: got %0h expected 0", k, grant_val); end
    end
  endtask

  task automatic test_hdr_stall();
    tick(); eng_hdr_rdy = 1'b0; drive_src(1, 1'b1, 1'b1, 0, 1'b0); #1;
    tick(); #1;
    n_cmp++;
    if ({eng_hdr_val, src_hdr_rdy, src_data_rdy} !== 9'b1_0000_0010) begin
      n_err++; $display("FAIL stall_rdy: got %0h expected 102", {eng_hdr_val, src_hdr_rdy, src_data_rdy});
    end
    tick(); drive_src(1, 1'b1, 1'b1, 1, 1'b1); #1;
    n_cmp++;
    if ({eng_data_last, eng_data} !== {1'b1, dat_of(1, 1)}) begin
      n_err++; $display("FAIL stall_last: got %0h expected %0h", {eng_data_last, eng_data}, {1'b1, dat_of(1, 1)});
    end
    tick(); drive_src(1, 1'b1, 1'b0, 1, 1'b0); #1;
    n_cmp++;
    if ({grant_val, eng_hdr_val, eng_data_val, src_data_rdy} !== 7'b110_0000) begin
      n_err++; $display("FAIL stall_data_done: got %0h expected 60", {grant_val, eng_hdr_val, eng_data_val, src_data_rdy});
    end
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      n_cmp++;
      if (grant_val !== 1'b1) begin n_err++; $display("FAIL stall_hold_%0d: got %0h expected 1", c, grant_val); end
    end
    tick(); eng_hdr_rdy = 1'b1; #1;
    n_cmp++;
    if ({grant_val, src_hdr_rdy} !== 5'b1_0010) begin
      n_err++; $display("FAIL stall_hdr_accept: got %0h expected 12", {grant_val, src_hdr_rdy});
    end
    tick(); clr_src(); #1;
    n_cmp++;
    if (grant_val !== 1'b0) begin n_err++; $display("FAIL stall_to_idle: got %0h expected 0", grant_val); end
  endtask

  task automatic test_reset_mid();
    tick(); drive_src(0, 1'b1, 1'b1, 0, 1'b0); #1;
    tick(); #1;
    tick(); drive_src(0, 1'b0, 1'b1, 1, 1'b0); #1;
    tick(); drive_src(0, 1'b0, 1'b1, 2, 1'b0); #1;
    n_cmp++;
    if ({grant_val, grant_src, eng_data} !== {3'b1_00, dat_of(0, 2)}) begin
      n_err++; $display("FAIL rmid_before: got %0h expected %0h", {grant_val, grant_src, eng_data}, {3'b1_00, dat_of(0, 2)});
    end
    #2; rst_n = 1'b0; #1;
    n_cmp++;
    if ({grant_val, grant_src, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val} !== 12'h0) begin
      n_err++; $display("FAIL rmid_async_clear: got %0h expected 0",
        {grant_val, grant_src, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val});
    end
    clr_src();
    tick(); tick();
    drive_src(1, 1'b1, 1'b1, 0, 1'b1);
    drive_src(3, 1'b1, 1'b1, 0, 1'b1);
    rst_n = 1'b1; #1;
    n_cmp++;
    if ({grant_val, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val} !== 11'h0) begin
      n_err++; $display("FAIL rmid_first_cycle: got %0h expected 0",
        {grant_val, src_hdr_rdy, src_data_rdy, eng_hdr_val, eng_data_val});
    end
    tick(); #1;
    n_cmp++;
    if ({grant_val, grant_src, eng_hdr} !== {3'b1_01, hdr_of(1)}) begin
      n_err++; $display("FAIL rmid_regrant_src1: got %0h expected %0h", {grant_val, grant_src, eng_hdr}, {3'b1_01, hdr_of(1)});
    end
    tick(); clr_src(); #1;
    n_cmp++;
    if (grant_val !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %0h expected 0", grant_val); end
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   got  = 0;
    bit   hdr_taken = 1'b0;
    bit   seen = 1'b0;
    bit   ended = 1'b0;
    logic rdy_t = 1'b0;
    tick();
    drive_src(3, 1'b1, 1'b1, 0, 1'b0);
    src_data_val[0] = 1'b1;
    src_data_val[1] = 1'b1;
    #1;
    for (int c = 0; c < 40 && !ended; c++) begin
      tick();
      drive_src(3, !hdr_taken, sent < 4, sent, sent == 3);
      eng_data_rdy = rdy_t;
      rdy_t = ~rdy_t;
      #1;
      n_cmp++;
      if ((src_data_rdy & 4'b0111) !== 4'b0000) begin
        n_err++; $display("FAIL bp_other_rdy: got %0h expected 0", src_data_rdy);
      end
      if (eng_data_val && eng_data_rdy) begin
        n_cmp++;
        if (eng_data !== dat_of(3, got)) begin
          n_err++; $display("FAIL bp_flit_%0d: got %0h expected %0h", got, eng_data, dat_of(3, got));
        end
        got++;
      end
      if (src_data_rdy[3] && src_data_val[3]) sent++;
      if (src_hdr_rdy[3] && src_hdr_val[3]) hdr_taken = 1'b1;
      if (grant_val) seen = 1'b1;
      else if (seen) ended = 1'b1;
    end
    n_cmp++;
    if (ended !== 1'b1) begin n_err++; $display("FAIL bp_timeout: got %0h expected 1", ended); end
    n_cmp++;
    if (got !== 4) begin n_err++; $display("FAIL bp_handshakes: got %0d expected 4", got); end
    clr_src();
    eng_data_rdy = 1'b1;
  endtask

  task automatic test_orphan();
    tick();
    clr_src();
    src_data_val[3] = 1'b1;
    src_data[3*DATA_W +: DATA_W] = dat_of(3, 9);
    src_data_last[3] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(); #1;
      n_cmp++;
      if ({grant_val, src_data_rdy} !== 5'b0) begin
        n_err++; $display("FAIL orphan_%0d: got %0h expected 0", c, {grant_val, src_data_rdy});
      end
    end
    clr_src();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hdr_stall();
    test_reset_mid();
    test_backpressure();
    test_orphan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mrp_rx_engine_arb.md
# mrp_rx_engine_arb

Arbiter that shares one MRP engine receive port among `NUM_SRC` NoC receive-input controllers. Each controller presents an MRP header stream and a data-flit stream for one message at a time. The arbiter locks the engine to a single source for a whole message, meaning one header plus all data flits through the flit flagged last. It rotates priority round-robin between messages. It sits between the per-tile receive-input controllers and the MRP engine.

## Interface
- `NUM_SRC`, 4, number of requesting controllers (≥1)
- `HDR_W`, 128, header payload width
- `DATA_W`, 512, data-flit payload width
- `SRC_W`, derived, `max(1, $clog2(NUM_SRC))`

Clock and reset:
- `clk` in 1: sole clock
- `rst_n` in 1: reset, asynchronous, active-low

Source side:
- `src_hdr_val` in NUM_SRC: per-source header valid
- `src_hdr` in NUM_SRC*HDR_W: headers, source i at bits [i*HDR_W +: HDR_W]
- `src_hdr_rdy` out NUM_SRC: header accepted
- `src_data_val` in NUM_SRC: data valid
- `src_data` in NUM_SRC*DATA_W: data flits
- `src_data_last` in NUM_SRC: final flit of message
- `src_data_rdy` out NUM_SRC: data accepted

Engine side:
- `eng_hdr_val` out 1, `eng_hdr` out HDR_W, `eng_hdr_rdy` in 1: header to engine
- `eng_data_val` out 1, `eng_data` out DATA_W, `eng_data_last` out 1, `eng_data_rdy` in 1: data to engine
- `grant_val` out 1: a message is in flight
- `grant_src` out SRC_W: index of the owning source

## Operation
- States: IDLE, BUSY. Per-message flags `hdr_done` and `data_done`. Priority pointer `prio` (SRC_W).
- **IDLE**
  - All source `rdy`, `eng_*_val` and `grant_val` are 0.
  - If any `src_hdr_val` is set, pick the first set bit searching from `prio` upward with wrap. Register it in `grant_src`, clear both flags, go to BUSY.
  - Only `src_hdr_val` requests arbitration. Data valid without a header is ignored.
- **BUSY**, g = `grant_src`
  - `eng_hdr_val = src_hdr_val[g] & !hdr_done`, with `eng_hdr = src_hdr[g]`.
  - `src_hdr_rdy[g] = eng_hdr_rdy & !hdr_done`.
  - `eng_data_val = src_data_val[g] & !data_done`, with data and last muxed from g.
  - `src_data_rdy[g] = eng_data_rdy & !data_done`.
  - All other sources see `rdy = 0`. Header and data paths are independent and may transfer in the same cycle.
  - A header handshake sets `hdr_done`. A data handshake with last set sets `data_done`.
  - When both are done, counting handshakes in the current cycle: go to IDLE, set `prio = (g+1) mod NUM_SRC`, clear `grant_val`.
- Each message carries exactly one header and at least one data flit.
- Flits after last belong to the next message and are not accepted until that source is re-granted.
- Combinational paths from `eng_*_rdy` to `src_*_rdy` are permitted. There is no combinational path from `src_*_val` to any `rdy`.

## Timing
- Reset, asynchronous on `rst_n` low: state IDLE, `prio=0`, `grant_src=0`, flags 0, `grant_val=0`. All `val` and `rdy` outputs are 0 while in reset and on the first cycle after release.
- Arbitration latency: a header valid in IDLE at cycle t is offered to the engine at t+1.
- There is one mandatory IDLE cycle between consecutive messages.
- Peak throughput is one data flit per cycle while BUSY.
- A source deasserting valid mid-message is a stall, not an abort. The grant holds indefinitely.
- With `NUM_SRC=1`, `prio` stays 0 and behaviour is otherwise identical.
- Reset asserted mid-message aborts it. No partial-message state survives.

## Structure
- Package `mrp_rx_arb_pkg` holds the `arb_state_e` enum (IDLE=1'b0, BUSY=1'b1, undefined = 'X).
- Sub-module `mrp_rr_pick`: combinational rotate-priority picker. Inputs are the request vector and `prio`. Outputs are `pick_val` and `pick_idx`. It is instantiated once.
- Top level holds the FSM, flags, registers and muxes.

## Test plan
- **Single message.** Source 2 sends a header and 3 data flits with the engine always ready.
  - `grant_src=2` one cycle after header valid.
  - Header and flit 0 transfer in the same cycle.
  - `eng_data_last` is seen on the 3rd flit, then IDLE, and `prio=3`.
- **Round-robin.** All 4 sources hold a header plus 1 flit continuously.
  - Grant order is 0,1,2,3,0, each separated by one IDLE cycle.
- **Header stall.** Hold `eng_hdr_rdy=0` for 5 cycles while data flows.
  - All data, including last, completes first. The state stays BUSY until the header is accepted, then goes to IDLE the next cycle.
- **Data backpressure.** Toggle `eng_data_rdy` every cycle on a 4-flit message.
  - Exactly 4 data handshakes occur, in order, with no flit duplication.
  - `src_data_rdy` of non-granted sources stays 0 throughout.
- **Reset mid-message.** Drop `rst_n` asynchronously after 2 of 4 flits.
  - All outputs go to 0 immediately; after release, `prio=0`.
  - A new header from source 1 is granted normally.
- **Orphan data.** `src_data_val[3]=1` with no header.
  - No grant is issued and `src_data_rdy[3]` stays 0 for 20 cycles.
